data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 tb/tb_data_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for a CPU MEM stage: word-addressed RAM with byte-lane
// writes, plus a small MMIO window holding a transmit byte FIFO, its status
// register, and a free-running cycle counter.
module data_mem_responder #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_byte_slct,
  input  logic [31:0] data_to_write_mem,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] data_from_mem,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Address decode; the two lowest address bits never matter.
  logic          is_mmio;
  logic          sel_txdata;
  logic          sel_status;
  logic          sel_cycle;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_bits;

  assign is_mmio          = (mem_addr[31:28] == 4'h1);
  assign sel_txdata       = is_mmio && (mem_addr[27:2] == 26'h0);
  assign sel_status       = is_mmio && (mem_addr[27:2] == 26'h1);
  assign sel_cycle        = is_mmio && (mem_addr[27:2] == 26'h2);
  assign ram_idx          = mem_addr[AW+1:2];
  assign unused_addr_bits = ^mem_addr[1:0];

  // ---------------------------------------------------------------------------
  // Data RAM
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [RAM_WORDS];
  logic        ram_we;

  assign ram_we = mem_we && !is_mmio && !rst;

  // Byte-lane RAM write; reads below see the pre-edge contents.
  // NOTE: the RAM array has no reset branch -- resetting a memory forces it
  // into flops instead of a RAM macro, and software must not rely on its value.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_byte_slct[i]) begin
          ram_q[ram_idx][8*i +: 8] <= data_to_write_mem[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_q [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic          full, empty;
  logic          push_req, push_ok, push_drop, pop;
  logic [3:0]    count_ext;
  logic [31:0]   status;

  assign full      = (count_q == CW'(TX_DEPTH));
  assign empty     = (count_q == '0);
  assign tx_valid  = !empty;
  assign tx_data   = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;
  assign count_ext = 4'(count_q);
  assign status    = {26'b0, count_ext[2:0], overflow_q, full, empty};

  // FIFO next state: a pop frees the slot a simultaneous push needs when full.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    push_req   = mem_we && sel_txdata && mem_byte_slct[0];
    pop        = tx_valid && tx_ready;
    push_ok    = push_req && (!full || pop);
    push_drop  = push_req && full && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
    if (mem_re && sel_status) overflow_d = 1'b0;
    if (push_drop)            overflow_d = 1'b1;
  end

  // FIFO control registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      fifo_q[wr_ptr_q] <= data_to_write_mem[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_q, cycle_d;

  // Any write to CYCLE clears it, overriding the increment.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (mem_we && sel_cycle) cycle_d = '0;
  end

  // Cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) cycle_q <= '0;
    else     cycle_q <= cycle_d;
  end

  // ---------------------------------------------------------------------------
  // Combinational read mux
  // ---------------------------------------------------------------------------
  // Full-word read of RAM or MMIO; zero when no read is requested.
  always_comb begin
    data_from_mem = '0;
    if (mem_re) begin
      if (!is_mmio)        data_from_mem = ram_q[ram_idx];
      else if (sel_status) data_from_mem = status;
      else if (sel_cycle)  data_from_mem = cycle_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

  localparam logic [31:0] TXDATA_A = 32'h1000_0000;
  localparam logic [31:0] STATUS_A = 32'h1000_0004;
  localparam logic [31:0] CYCLE_A  = 32'h1000_0008;
  localparam logic [31:0] OTHER_A  = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_slct;
  logic [31:0] data_to_write_mem;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] data_from_mem;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.RAM_WORDS(1024), .TX_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_addr          (mem_addr),
    .mem_byte_slct     (mem_byte_slct),
    .data_to_write_mem (data_to_write_mem),
    .mem_we            (mem_we),
    .mem_re            (mem_re),
    .data_from_mem     (data_from_mem),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                       input logic [3:0] slct, input logic [31:0] wdata);
    mem_we            = we;
    mem_re            = re;
    mem_addr          = addr;
    mem_byte_slct     = slct;
    data_to_write_mem = wdata;
    #1;
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [3:0] slct,
                           input logic [31:0] wdata);
    drive(1'b1, 1'b0, addr, slct, wdata);
    tick();
  endtask

  // Read observed before the edge; the edge is then taken.
  task automatic read_check(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp);
    drive(1'b0, 1'b1, addr, 4'h0, 32'h0);
    check(tag, data_from_mem, exp);
    tick();
  endtask

  logic [7:0] drain_exp [4];

  initial begin
    drain_exp[0] = 8'h42;
    drain_exp[1] = 8'h43;
    drain_exp[2] = 8'h44;
    drain_exp[3] = 8'h50;

    rst      = 1'b1;
    tx_ready = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h0);
    check("rst_rdata_idle", data_from_mem, 32'h0);

    // Cycle counter: 10 edges after reset.
    repeat (10) tick();
    read_check("cycle_10", CYCLE_A, 32'd10);

    // Preloaded all-ones counter wraps to zero on the next edge.
    force dut.cycle_q = 32'hFFFF_FFFF;
    drive(1'b0, 1'b1, CYCLE_A, 4'h0, 32'h0);
    check("cycle_preload_rd", data_from_mem, 32'hFFFF_FFFF);
    check("cycle_wrap_next", dut.cycle_d, 32'h0);
    release dut.cycle_q;

    // Write (with no byte lanes) clears the counter.
    drive(1'b1, 1'b0, CYCLE_A, 4'h0, 32'h1234_5678);
    tick();
    read_check("cycle_cleared", CYCLE_A, 32'h0);

    // RAM byte-lane writes and aliasing.
    mem_write(32'h0000_0010, 4'hF, 32'hAABB_CCDD);
    mem_write(32'h0000_0010, 4'b0010, 32'h0000_1100);
    read_check("ram_lane_merge", 32'h0000_0010, 32'hAABB_11DD);
    read_check("ram_alias_hi", 32'h0000_1010, 32'hAABB_11DD);
    read_check("ram_alias_top", 32'h2000_0012, 32'hAABB_11DD);
    mem_write(32'h0000_0010, 4'h0, 32'hFFFF_FFFF);
    read_check("ram_slct0_nowrite", 32'h0000_0010, 32'hAABB_11DD);
    drive(1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
    check("ram_no_re_zero", data_from_mem, 32'h0);

    // Same-cycle read/write returns old contents.
    mem_write(32'h0000_0020, 4'hF, 32'h0);
    drive(1'b1, 1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678);
    check("rw_same_old", data_from_mem, 32'h0);
    tick();
    read_check("rw_same_new", 32'h0000_0020, 32'h1234_5678);

    // MMIO odds and ends.
    read_check("status_empty", STATUS_A, 32'h0000_0001);
    read_check("txdata_rd_zero", TXDATA_A, 32'h0);
    mem_write(OTHER_A, 4'hF, 32'hFFFF_FFFF);
    read_check("other_mmio_zero", OTHER_A, 32'h0);
    mem_write(TXDATA_A, 4'b0010, 32'h0000_7777);
    read_check("push_lane0_off", STATUS_A, 32'h0000_0001);

    // Fill and overflow.
    for (int i = 0; i < 5; i++) mem_write(TXDATA_A, 4'h1, 32'h41 + i);
    read_check("status_overflow", STATUS_A, 32'h0000_0026);
    read_check("status_ovf_clear", STATUS_A, 32'h0000_0022);
    check("full_head", {24'b0, tx_data}, 32'h41);

    // Push while full and popping is accepted.
    tx_ready = 1'b1;
    mem_write(TXDATA_A, 4'h1, 32'h0000_0050);
    read_check("full_pushpop_st", STATUS_A, 32'h0000_0022);
    // The read above also popped 0x42 at its edge.
    drain_exp[0] = 8'h43;
    drain_exp[1] = 8'h44;
    drain_exp[2] = 8'h50;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain_valid_%0d", i), {31'b0, tx_valid}, 32'h1);
      check($sformatf("drain_data_%0d", i), {24'b0, tx_data}, {24'b0, drain_exp[i]});
      tick();
    end
    check("drained_valid", {31'b0, tx_valid}, 32'h0);
    read_check("drained_status", STATUS_A, 32'h0000_0001);

    // Push and pop together while empty: push only.
    mem_write(TXDATA_A, 4'h1, 32'h0000_0060);
    tx_ready = 1'b0;
    check("empty_pp_valid", {31'b0, tx_valid}, 32'h1);
    check("empty_pp_data", {24'b0, tx_data}, 32'h60);
    read_check("empty_pp_status", STATUS_A, 32'h0000_0008);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("empty_pp_popped", {31'b0, tx_valid}, 32'h0);

    // Reset mid-operation discards FIFO and suppresses the same-cycle push.
    for (int i = 0; i < 3; i++) mem_write(TXDATA_A, 4'h1, 32'h71 + i);
    rst = 1'b1;
    mem_write(TXDATA_A, 4'h1, 32'h0000_0074);
    rst = 1'b0;
    check("midrst_valid", {31'b0, tx_valid}, 32'h0);
    drive(1'b0, 1'b1, CYCLE_A, 4'h0, 32'h0);
    check("midrst_cycle", data_from_mem, 32'h0);
    read_check("midrst_status", STATUS_A, 32'h0000_0001);

    // RAM write suppressed during reset.
    rst = 1'b1;
    mem_write(32'h0000_0020, 4'hF, 32'hDEAD_BEEF);
    rst = 1'b0;
    read_check("rst_ram_nowrite", 32'h0000_0020, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
